// File: rtl/hilo_muldiv_ctrl_if.sv
// Operand/handshake bus between the HI/LO controller and an iterative signed divider.
interface hilo_muldiv_ctrl_if;
    localparam int unsigned XLEN = 32;

    logic [XLEN-1:0] div_dividend;
    logic [XLEN-1:0] div_divisor;
    logic            div_start;
    logic            div_busy;
    logic [XLEN-1:0] div_q;
    logic [XLEN-1:0] div_r;

    modport master (
        output div_dividend, div_divisor, div_start,
        input  div_busy, div_q, div_r
    );

    modport slave (
        input  div_dividend, div_divisor, div_start,
        output div_busy, div_q, div_r
    );
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO register owner: sequences an external divider, handles MTHI/MTLO and divide-by-zero.
// Define HILO_MULT_EN to add single-cycle MULT/MULTU into {hi,lo}.
module hilo_muldiv_ctrl #(
    parameter int unsigned MAX_WAIT = 48
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        err,
    hilo_muldiv_ctrl_if.master div_if
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

    localparam logic [2:0] OP_DIV   = 3'd1;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
`ifdef HILO_MULT_EN
    localparam logic [2:0] OP_MULT  = 3'd2;
    localparam logic [2:0] OP_MULTU = 3'd3;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_RELEASE,
        ST_WAIT
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic              err_q, err_d;
    logic [XLEN-1:0]   dividend_q, dividend_d;
    logic [XLEN-1:0]   divisor_q, divisor_d;
    logic              start_q, start_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              div_req;
`ifdef HILO_MULT_EN
    logic [2*XLEN-1:0] prod_s;
    logic [2*XLEN-1:0] prod_u;
`endif

    // A real divide request; divide-by-zero is resolved locally without the divider.
    assign div_req = op_valid && (op == OP_DIV) && (rt_val != '0);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            hi_q       <= '0;
            lo_q       <= '0;
            err_q      <= 1'b0;
            dividend_q <= '0;
            divisor_q  <= '0;
            start_q    <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            err_q      <= err_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            start_q    <= start_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        err_d      = 1'b0;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        start_d    = 1'b0;
        wait_cnt_d = wait_cnt_q;
`ifdef HILO_MULT_EN
        prod_s = {{XLEN{rs_val[XLEN-1]}}, rs_val} * {{XLEN{rt_val[XLEN-1]}}, rt_val};
        prod_u = {{XLEN{1'b0}}, rs_val} * {{XLEN{1'b0}}, rt_val};
`endif

        case (state_q)
            ST_IDLE: begin
                wait_cnt_d = '0;
                if (op_valid) begin
                    case (op)
                        OP_DIV: begin
                            if (rt_val == '0) begin
                                hi_d = rs_val;
                                lo_d = '1;
                            end else if (!div_if.div_busy) begin
                                dividend_d = rs_val;
                                divisor_d  = rt_val;
                                start_d    = 1'b1;
                                state_d    = ST_LAUNCH;
                            end
                        end
                        OP_MTHI: hi_d = rs_val;
                        OP_MTLO: lo_d = rs_val;
`ifdef HILO_MULT_EN
                        OP_MULT:  {hi_d, lo_d} = prod_s;
                        OP_MULTU: {hi_d, lo_d} = prod_u;
`endif
                        default: ;
                    endcase
                end
            end
            ST_LAUNCH: state_d = ST_RELEASE;
            ST_RELEASE: begin
                wait_cnt_d = '0;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (!div_if.div_busy) begin
                    hi_d       = div_if.div_r;
                    lo_d       = div_if.div_q;
                    wait_cnt_d = '0;
                    state_d    = ST_IDLE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    // Divider hung: abandon the run and leave HI/LO untouched.
                    err_d      = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Stall covers both an accepted divide and one blocked behind a still-busy divider.
    assign stall = reset && ((state_q != ST_IDLE) || div_req);

    assign hi                  = hi_q;
    assign lo                  = lo_q;
    assign err                 = err_q;
    assign div_if.div_dividend = dividend_q;
    assign div_if.div_divisor  = divisor_q;
    assign div_if.div_start    = start_q;
endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl with a 32-cycle divider model and a HI/LO reference model.
module tb_hilo_muldiv_ctrl;
    localparam int DIV_LAT = 32;

    logic        clock = 1'b0;
    logic        reset;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] rs_val, rt_val;
    logic        stall, err;
    logic [31:0] hi, lo;

    int n_cmp = 0;
    int n_mis = 0;

    logic [31:0] exp_hi, exp_lo;

    hilo_muldiv_ctrl_if div_if();

    hilo_muldiv_ctrl #(.MAX_WAIT(48)) dut (
        .clock    (clock),
        .reset    (reset),
        .op_valid (op_valid),
        .op       (op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .stall    (stall),
        .hi       (hi),
        .lo       (lo),
        .err      (err),
        .div_if   (div_if)
    );

    always #5 clock = ~clock;

    // Divider model: launches on div_start falling, busy for DIV_LAT cycles, never reset by the DUT.
    logic               m_busy = 1'b0;
    logic               m_prev = 1'b0;
    bit                 hang   = 1'b0;
    int                 m_cnt  = 0;
    logic signed [31:0] m_a = 0, m_b = 1, m_q = 0, m_r = 0;

    assign div_if.div_busy = m_busy;
    assign div_if.div_q    = m_q;
    assign div_if.div_r    = m_r;

    always @(posedge clock) begin
        m_prev <= div_if.div_start;
        if (m_prev === 1'b1 && div_if.div_start === 1'b0) begin
            m_busy <= 1'b1;
            m_cnt  <= DIV_LAT;
            m_a    <= div_if.div_dividend;
            m_b    <= div_if.div_divisor;
        end else if (m_busy && !hang) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_busy <= 1'b0;
                m_q    <= m_a / m_b;
                m_r    <= m_a % m_b;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Architectural effect of a single-cycle operation on HI/LO.
    function automatic void ref_apply(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          p;
        longint unsigned pu;
        case (o)
            3'd1: if (b == 0) begin exp_hi = a; exp_lo = 32'hFFFF_FFFF; end
`ifdef HILO_MULT_EN
            3'd2: begin p  = longint'(signed'(a)) * longint'(signed'(b)); {exp_hi, exp_lo} = p; end
            3'd3: begin pu = {32'd0, a} * {32'd0, b}; {exp_hi, exp_lo} = pu; end
`endif
            3'd4: exp_hi = a;
            3'd5: exp_lo = a;
            default: ;
        endcase
    endfunction

    task automatic single_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
        op_valid = 1'b1; op = o; rs_val = a; rt_val = b;
        #1;
        check({tag, "_stall"}, 64'(stall), 64'(0));
        ref_apply(o, a, b);
        step();
        op_valid = 1'b0;
        check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
        check({tag, "_nostart"}, 64'(div_if.div_start), 64'(0));
    endtask

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input bit hang_run,
                           input int exp_stall, input string tag);
        int nstall = 0, nerr = 0, launched = 0;
        bit stable = 1, early = 0, blocked_ok = 1, pre_ok = 1;
        logic signed [31:0] sa, sb;
        sa = a; sb = b;
        hang = hang_run;
        op_valid = 1'b1; op = 3'd1; rs_val = a; rt_val = b;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (div_if.div_start === 1'b1) begin
                if (m_busy) early = 1;
                launched++;
                op_valid = 1'b0;
            end
            if (launched > 0 && (div_if.div_dividend !== a || div_if.div_divisor !== b)) stable = 0;
            if (launched == 0 && (hi !== exp_hi || lo !== exp_lo)) pre_ok = 0;
            #1;
            if (stall === 1'b1) nstall++;
            else if (op_valid) blocked_ok = 0;
            if (err === 1'b1) nerr++;
            if (stall !== 1'b1 && !op_valid) break;
            step();
        end
        op_valid = 1'b0;
        if (!hang_run) begin
            exp_hi = sa % sb;
            exp_lo = sa / sb;
        end
        if (exp_stall >= 0) check({tag, "_stall_cycles"}, 64'(nstall), 64'(exp_stall));
        check({tag, "_launches"}, 64'(launched), 64'(1));
        check({tag, "_err_pulses"}, 64'(nerr), hang_run ? 64'(1) : 64'(0));
        check({tag, "_operands_stable"}, 64'(stable), 64'(1));
        check({tag, "_launch_while_busy"}, 64'(early), 64'(0));
        check({tag, "_stall_when_blocked"}, 64'(blocked_ok), 64'(1));
        check({tag, "_hilo_before_launch"}, 64'(pre_ok), 64'(1));
        check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
        step();
        check({tag, "_err_cleared"}, 64'(err), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0]  o;
        logic [31:0] a, b;

        // Reset with a divide presented: no stall, everything cleared.
        reset = 1'b0; op_valid = 1'b1; op = 3'd1; rs_val = 32'd5; rt_val = 32'd3;
        exp_hi = '0; exp_lo = '0;
        step();
        step();
        check("rst_stall", 64'(stall), 64'(0));
        check("rst_hi", 64'(hi), 64'(0));
        check("rst_lo", 64'(lo), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_start", 64'(div_if.div_start), 64'(0));
        check("rst_dividend", 64'(div_if.div_dividend), 64'(0));
        check("rst_divisor", 64'(div_if.div_divisor), 64'(0));
        op_valid = 1'b0;
        reset = 1'b1;
        step();

        run_div(32'd100, 32'd7, 1'b0, 36, "div_100_7");
        check("div_100_7_lo_const", 64'(lo), 64'(14));
        check("div_100_7_hi_const", 64'(hi), 64'(2));

        run_div(32'hFFFF_FF9C, 32'd7, 1'b0, 36, "div_m100_7");
        check("div_m100_7_lo_const", 64'(lo), 64'(32'hFFFF_FFF2));
        check("div_m100_7_hi_const", 64'(hi), 64'(32'hFFFF_FFFE));

        single_op(3'd1, 32'd5, 32'd0, "div_by_zero");
        check("div_by_zero_hi_const", 64'(hi), 64'(5));
        check("div_by_zero_lo_const", 64'(lo), 64'(32'hFFFF_FFFF));

        single_op(3'd4, 32'hCAFE_0001, 32'd0, "mthi");
        single_op(3'd5, 32'hBEEF_0002, 32'd0, "mtlo");
        single_op(3'd0, 32'h1234_5678, 32'd9, "nop");
        single_op(3'd7, 32'h1234_5678, 32'd9, "op7");

        single_op(3'd2, 32'hFFFF_FFFF, 32'd2, "mult");
`ifdef HILO_MULT_EN
        check("mult_hi_const", 64'(hi), 64'(32'hFFFF_FFFF));
        check("mult_lo_const", 64'(lo), 64'(32'hFFFF_FFFE));
`endif
        single_op(3'd3, 32'hFFFF_FFFF, 32'd2, "multu");
`ifdef HILO_MULT_EN
        check("multu_hi_const", 64'(hi), 64'(1));
        check("multu_lo_const", 64'(lo), 64'(32'hFFFF_FFFE));
`endif

        for (int i = 0; i < 30; i++) begin
            o = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            if (i % 4 == 0) a = 32'($urandom_range(0, 200)) - 32'd100;
            if (o == 3'd1 && $urandom_range(0, 3) == 0) b = '0;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
            if (o == 3'd1 && b != 0) run_div(a, b, 1'b0, 36, $sformatf("rnd%0d_div", i));
            else single_op(o, a, b, $sformatf("rnd%0d_op%0d", i, o));
        end

        // Reset in the middle of a division, then divide while the divider is still busy.
        op_valid = 1'b1; op = 3'd1; rs_val = 32'd1000; rt_val = 32'd3;
        step();
        op_valid = 1'b0;
        repeat (5) step();
        reset = 1'b0; op_valid = 1'b1; op = 3'd1; rs_val = 32'd77; rt_val = 32'hFFFF_FFFB;
        #1;
        check("midrst_stall", 64'(stall), 64'(0));
        step();
        op_valid = 1'b0;
        check("midrst_hi", 64'(hi), 64'(0));
        check("midrst_lo", 64'(lo), 64'(0));
        check("midrst_start", 64'(div_if.div_start), 64'(0));
        check("midrst_dividend", 64'(div_if.div_dividend), 64'(0));
        check("midrst_busy_still_high", 64'(m_busy), 64'(1));
        reset = 1'b1;
        exp_hi = '0; exp_lo = '0;
        run_div(32'd77, 32'hFFFF_FFFB, 1'b0, -1, "post_rst");
        check("post_rst_lo_const", 64'(lo), 64'(32'hFFFF_FFF1));
        check("post_rst_hi_const", 64'(hi), 64'(2));

        // Divider that never finishes: abort after the wait budget.
        run_div(32'd123, 32'd4, 1'b1, 51, "timeout");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/hilo_muldiv_ctrl.md
HILO_MULDIV_CTRL -- requirements
Module: hilo_muldiv_ctrl

Interface
REQ-001 Parameter MAX_WAIT, default 48, maximum cycles spent in WAIT before abort.
REQ-002 clock  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-low; sampled on rising edge of clock.
REQ-004 op_valid  in  1  operation request from the decode stage.
REQ-005 op  in  3  operation code: 0 NOP, 1 DIV (signed), 2 MULT, 3 MULTU, 4 MTHI, 5 MTLO; 6-7 treated as NOP.
REQ-006 rs_val, rt_val  in  32 each  operands: dividend/multiplicand = rs_val, divisor/multiplier = rt_val, MTHI/MTLO source = rs_val.
REQ-007 stall  out  1  combinational; holds the CPU front end while high.
REQ-008 hi, lo  out  32 each  architectural HI/LO registers, read directly by MFHI/MFLO.
REQ-009 err  out  1  one-cycle pulse on divider timeout.
REQ-010 div_dividend, div_divisor  out  32 each  registered operands presented to the divider.
REQ-011 div_start  out  1  registered; divider launches on its 1->0 transition.
REQ-012 div_busy  in  1  divider iterating.
REQ-013 div_q, div_r  in  32 each  signed quotient/remainder, valid when div_busy is low after a run.

Function
REQ-014 FSM states: IDLE, LAUNCH, RELEASE, WAIT; no other states SHALL be reachable.
REQ-015 IDLE, op_valid, op=DIV, rt_val!=0, div_busy=0: latch rs_val/rt_val into div_dividend/div_divisor, go to LAUNCH.
REQ-016 LAUNCH: div_start=1 for exactly one cycle, then go to RELEASE.
REQ-017 RELEASE: div_start=0; go to WAIT unconditionally (divider raises busy at this cycle's end).
REQ-018 WAIT, div_busy=0: hi<=div_r, lo<=div_q, go to IDLE; div_busy=1: stay and increment wait counter.
REQ-019 WAIT counter reaching MAX_WAIT: go to IDLE, pulse err, hi/lo unchanged.
REQ-020 stall = (state!=IDLE) OR (IDLE AND op_valid AND op=DIV AND (rt_val!=0) AND accept-or-blocked); with a 32-iteration divider a DIV stalls exactly 36 cycles (accept + LAUNCH + RELEASE + 32 busy + capture).
REQ-021 IDLE, op=DIV, div_busy=1: stall high, no launch, until div_busy falls (covers divider still running after reset).
REQ-022 DIV with rt_val=0: no launch, no stall; next edge hi<=rs_val, lo<=32'hFFFFFFFF.
REQ-023 MTHI: hi<=rs_val next edge; MTLO: lo<=rs_val next edge; no stall; only accepted in IDLE.
REQ-024 op_valid while state!=IDLE SHALL be ignored (stall already high; decode re-presents it).
REQ-025 div_dividend/div_divisor SHALL stay stable from LAUNCH through WAIT.

Reset
REQ-026 reset=0 at an edge: state=IDLE, hi=0, lo=0, div_start=0, div_dividend=0, div_divisor=0, err=0, wait counter=0.
REQ-027 Reset mid-division abandons the run; its result SHALL never be written to hi/lo.
REQ-028 stall SHALL be 0 during reset except via REQ-021 once reset releases.

Configuration
REQ-029 Macro HILO_MULT_EN defined: MULT/MULTU in IDLE write {hi,lo} <= 64-bit signed/unsigned product of rs_val, rt_val on the next edge, no stall.
REQ-030 Macro HILO_MULT_EN undefined: MULT/MULTU act as NOP; hi/lo unchanged; no multiplier logic synthesized.

Verification
REQ-031 DIV rs=100, rt=7 with a 32-cycle divider model -> stall high 36 cycles, then lo=14, hi=2, err=0.
REQ-032 DIV rs=-100 (0xFFFFFF9C), rt=7 -> lo=0xFFFFFFF2 (-14), hi=0xFFFFFFFE (-2).
REQ-033 DIV rs=5, rt=0 -> no div_start pulse, stall never high, next cycle hi=5, lo=0xFFFFFFFF.
REQ-034 Divider model holding busy forever -> return to IDLE after 48 WAIT cycles, err pulses once, hi/lo unchanged.
REQ-035 reset=0 during WAIT, then DIV issued while model busy still high -> hi/lo=0, stall high until busy falls, then new launch and correct result.
REQ-036 HILO_MULT_EN defined: MULT 0xFFFFFFFF x 2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE; MULTU same -> hi=1, lo=0xFFFFFFFE; undefined: hi/lo unchanged.
